add_sub_param: RTL and testbench

ADD_SUB_PARAM -- requirements
Module: add_sub_param

---
 rtl/add_sub_param.sv | 252 +++++++++++++++++++++++++
 tb/tb_add_sub_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_param.sv
// -----------------------------------------------------------------------------
// add_sub_param
//
// Sign-magnitude adder/subtractor. It works through the operands CHUNK bits
// per clock, starting with the least significant chunk. Each operand arrives as
// an unsigned magnitude. The sign of each operand comes from the op code. The
// block applies the signs, does a chunked magnitude add or subtract, and then
// normalises the raw sum back to sign-magnitude form.
//
// Sequence of states:
//   IDLE -> ADD (N = WIDTH/CHUNK cycles) -> NORM (1 cycle) -> DONE (1 cycle)
//   IDLE -> DONE directly when the op code is invalid.
//
// Ports
//   clk_i        rising-edge clock for all state
//   rst_ni       asynchronous active-low reset
//   start_i      operation request, sampled only in IDLE
//   control_i    op code: 1000 +A+B, 1001 +A-B, 1010 -A+B, 1011 -A-B
//   a_i, b_i     unsigned operand magnitudes, WIDTH bits
//   busy_o       high whenever the FSM is not in IDLE
//   finish_o     one-cycle completion pulse (the DONE state)
//   c_o          result magnitude
//   sign_o       result sign (1 = negative); a zero result is never negative
//   overflow_o   result magnitude did not fit in WIDTH bits
//   error_o      last request carried an invalid op code
//
// WIDTH must be an integer multiple of CHUNK.
// -----------------------------------------------------------------------------
module add_sub_param #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [3:0]       control_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             finish_o,
  output logic [WIDTH-1:0] c_o,
  output logic             sign_o,
  output logic             overflow_o,
  output logic             error_o
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------

  // Adds one chunk. A subtract is done as a + ~b + cin, so the caller supplies
  // cin = 1 on the first chunk of a subtract.
  // Returns {carry_out, chunk_sum}.
  function automatic logic [CHUNK:0] chunk_add(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             sub,
    input logic             cin
  );
    logic [CHUNK-1:0] b_eff;
    b_eff = sub ? ~b : b;
    return {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, cin};
  endfunction

  // Converts the raw chunked result into sign-magnitude form.
  // Returns {magnitude, sign, overflow}.
  // For a subtract, a final carry of 0 means |B| > |A|. In that case the sum
  // holds the two's complement of the true magnitude, and the sign flips.
  function automatic logic [WIDTH+1:0] normalize(
    input logic [WIDTH-1:0] sum,
    input logic             carry,
    input logic             sub,
    input logic             sign_a
  );
    logic [WIDTH-1:0] mag;
    logic             sgn;
    logic             ovf;
    mag = sum;
    sgn = sign_a;
    ovf = 1'b0;
    if (!sub) begin
      ovf = carry;
    end else if (!carry) begin
      mag = ~sum + WIDTH'(1);
      sgn = ~sign_a;
    end
    // A true zero is always reported as positive. An overflowed add that
    // wraps to zero keeps its sign, because its real magnitude is not zero.
    if ((mag == '0) && !ovf) begin
      sgn = 1'b0;
    end
    return {mag, sgn, ovf};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;       // operand A, shifted right one chunk per ADD cycle
  logic [WIDTH-1:0]  b_q, b_d;       // operand B, shifted right one chunk per ADD cycle
  logic [WIDTH-1:0]  sum_q, sum_d;   // chunk sums, shifted in from the top
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sa_q, sa_d;     // sign of A
  logic              sb_q, sb_d;     // sign of B
  logic [WIDTH-1:0]  c_q, c_d;
  logic              sign_q, sign_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic              valid_op;
  logic              sub_op;
  logic              cin;
  logic [CHUNK:0]    chunk_res;
  logic [WIDTH+1:0]  norm_res;

  assign valid_op = (control_i[3:2] == 2'b10);

  // Different operand signs turn the magnitude add into a subtract.
  assign sub_op   = sa_q ^ sb_q;

  // The carry register is cleared at launch. On the first chunk the carry-in
  // is the subtract flag instead, which supplies the +1 of A + ~B + 1.
  assign cin       = (cnt_q == '0) ? sub_op : carry_q;
  assign chunk_res = chunk_add(a_q[CHUNK-1:0], b_q[CHUNK-1:0], sub_op, cin);
  assign norm_res  = normalize(sum_q, carry_q, sub_op, sa_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    c_d     = c_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (valid_op) begin
            a_d     = a_i;
            b_d     = b_i;
            sa_d    = control_i[1];
            sb_d    = control_i[0];
            sum_d   = '0;
            carry_d = 1'b0;
            cnt_d   = '0;
            state_d = S_ADD;
          end else begin
            // An invalid op code completes at once with a cleared result.
            c_d     = '0;
            sign_d  = 1'b0;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_ADD: begin
        carry_d = chunk_res[CHUNK];
        // The new chunk enters at the top. After N shifts the LSB chunk
        // has reached bit 0.
        sum_d   = (sum_q >> CHUNK) | (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        c_d     = norm_res[WIDTH+1:2];
        sign_d  = norm_res[1];
        ovf_d   = norm_res[0];
        err_d   = 1'b0;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      c_q     <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      c_q     <= c_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy_o     = (state_q != S_IDLE);
  assign finish_o   = (state_q == S_DONE);
  assign c_o        = c_q;
  assign sign_o     = sign_q;
  assign overflow_o = ovf_q;
  assign error_o    = err_q;

endmodule

// File: tb/tb_add_sub_param.sv
module tb_add_sub_param;

  localparam int WIDTH     = 32;
  localparam int CHUNK     = 8;
  localparam int N         = WIDTH / CHUNK;
  localparam int LAT_VALID = N + 2;  // request edge to finish, also busy cycles
  localparam int LAT_INV   = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       control = 4'b0000;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             finish;
  logic [WIDTH-1:0] c;
  logic             sign;
  logic             overflow;
  logic             error;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [31:0] c;
    logic        s;
    logic        o;
    logic        e;
    int          issue;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t me;

  add_sub_param #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .control_i  (control),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (busy),
    .finish_o   (finish),
    .c_o        (c),
    .sign_o     (sign),
    .overflow_o (overflow),
    .error_o    (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per finish pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (finish) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_finish actual=1 expected=0 at cycle %0d", cyc);
          end else begin
            me = sb.pop_front();
            chk({me.name, "_C"},        c,                 me.c);
            chk({me.name, "_sign"},     32'(sign),         32'(me.s));
            chk({me.name, "_overflow"}, 32'(overflow),     32'(me.o));
            chk({me.name, "_error"},    32'(error),        32'(me.e));
            chk({me.name, "_latency"},  32'(cyc - me.issue), 32'(me.lat));
            chk({me.name, "_busy_cyc"}, 32'(busy_cnt),     32'(me.lat));
          end
        end
        if (!busy) busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_wait actual=busy expected=idle", name);
    end
  endtask

  task automatic push_exp(input string name, input logic [3:0] ctl, input logic [31:0] ec,
                          input logic es, input logic eo, input logic ee, input int issue);
    exp_t e;
    e.c     = ec;
    e.s     = es;
    e.o     = eo;
    e.e     = ee;
    e.issue = issue;
    e.lat   = (ctl[3:2] == 2'b10) ? LAT_VALID : LAT_INV;
    e.name  = name;
    sb.push_back(e);
  endtask

  // Drives one request for a single cycle, then scrambles the inputs. After
  // the request edge the inputs must have no effect on the result.
  task automatic issue(input string name, input logic [3:0] ctl, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] ec, input logic es,
                       input logic eo, input logic ee);
    @(negedge clk);
    wait_idle(name);
    start   = 1'b1;
    control = ctl;
    a       = av;
    b       = bv;
    push_exp(name, ctl, ec, es, eo, ee, cyc);
    @(negedge clk);
    start   = 1'b0;
    control = 4'b1011;
    a       = $urandom;
    b       = $urandom;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain pending=%0d expected=0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int c0;
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finish", 32'(finish), 32'd0);
    chk("rst_C", c, 32'd0);
    chk("rst_sign", 32'(sign), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst_n = 1'b1;

    // Directed vectors: name, control, A, B, C, sign, overflow, error
    issue("add_5_7",    4'b1000, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0);
    issue("sub_3_10",   4'b1001, 32'd3,          32'd10,         32'd7,          1'b1, 1'b0, 1'b0);
    issue("neg3_pos3",  4'b1010, 32'd3,          32'd3,          32'd0,          1'b0, 1'b0, 1'b0);
    issue("negmax_neg1",4'b1011, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b1, 1'b0);
    issue("add_1_1",    4'b1000, 32'd1,          32'd1,          32'd2,          1'b0, 1'b0, 1'b0);
    issue("invalid",    4'b0101, 32'd9,          32'd9,          32'd0,          1'b0, 1'b0, 1'b1);
    issue("sub_10_3",   4'b1001, 32'd10,         32'd3,          32'd7,          1'b0, 1'b0, 1'b0);
    issue("neg0_neg0",  4'b1011, 32'd0,          32'd0,          32'd0,          1'b0, 1'b0, 1'b0);
    issue("add_max_0",  4'b1000, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0);
    issue("neg256_255", 4'b1010, 32'h0000_0100,  32'h0000_00FF,  32'd1,          1'b1, 1'b0, 1'b0);
    issue("sub_borrow", 4'b1001, 32'h0001_0000,  32'h0000_FFFF,  32'd1,          1'b0, 1'b0, 1'b0);
    issue("add_carry",  4'b1000, 32'h00FF_00FF,  32'h0001_0001,  32'h0100_0100,  1'b0, 1'b0, 1'b0);
    drain("directed");

    // Result held stable while idle
    repeat (3) @(negedge clk);
    chk("hold_C", c, 32'h0100_0100);
    chk("hold_busy", 32'(busy), 32'd0);

    // start pulsed during ADD is ignored
    issue("ignored_start", 4'b1000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start   = 1'b1;
    control = 4'b1011;
    a       = 32'd100;
    b       = 32'd100;
    @(negedge clk);
    start   = 1'b0;
    drain("ignored_start");

    // start held high: back-to-back with period N+3
    @(negedge clk);
    wait_idle("b2b");
    start   = 1'b1;
    control = 4'b1000;
    a       = 32'd100;
    b       = 32'd200;
    c0      = cyc;
    push_exp("b2b_first", 4'b1000, 32'd300, 1'b0, 1'b0, 1'b0, c0);
    @(negedge clk);
    control = 4'b1011;
    a       = 32'd1;
    b       = 32'd2;
    push_exp("b2b_second", 4'b1011, 32'd3, 1'b1, 1'b0, 1'b0, c0 + N + 3);
    repeat (N + 3) @(negedge clk);
    start   = 1'b0;
    drain("b2b");

    // Reset in the middle of ADD aborts the operation
    @(negedge clk);
    start   = 1'b1;
    control = 4'b1000;
    a       = 32'd5;
    b       = 32'd5;
    @(negedge clk);
    start   = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_finish", 32'(finish), 32'd0);
    chk("abort_C", c, 32'd0);
    chk("abort_sign", 32'(sign), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue("post_reset", 4'b1000, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0);
    drain("post_reset");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
